// File: rtl/int_muldiv_iter.sv
// Iterative integer multiply/divide unit: shift-add multiply, restoring divide, val/rdy on both sides.
// Optional build macro INT_MULDIV_ITER_EARLY_TERM_EN stops MUL once the remaining multiplier bits are zero.
module int_muldiv_iter #(
  parameter int p_nbits              = 32,
  parameter int p_mul_bits_per_cycle = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2:0]         istream_msg_fn,
  input  logic [p_nbits-1:0] istream_msg_a,
  input  logic [p_nbits-1:0] istream_msg_b,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_nbits-1:0] ostream_msg
);

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  localparam int CW = $clog2(p_nbits + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(p_nbits / p_mul_bits_per_cycle - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(p_nbits - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_reg,  state_next;
  logic [2:0]         fn_reg,     fn_next;
  logic [p_nbits-1:0] a_reg,      a_next;
  logic [p_nbits-1:0] b_reg,      b_next;
  logic [p_nbits-1:0] acc_reg,    acc_next;
  logic [CW-1:0]      count_reg,  count_next;
  logic               sign_a_reg, sign_a_next;
  logic               sign_b_reg, sign_b_next;
  logic               b_zero_reg, b_zero_next;
  logic [p_nbits-1:0] result_reg, result_next;

  // In MUL, a_reg is the shifting multiplicand and b_reg the shifting multiplier.
  // In divide, a_reg shifts dividend bits out and quotient bits in; acc_reg is the partial remainder.
  logic [p_mul_bits_per_cycle-1:0][p_nbits-1:0] mul_pp;
  logic [p_nbits-1:0] mul_sum;

  genvar gi;
  generate
    for (gi = 0; gi < p_mul_bits_per_cycle; gi++) begin : g_mul_pp
      assign mul_pp[gi] = b_reg[gi] ? (a_reg << gi) : '0;
    end
  endgenerate

  always_comb begin
    mul_sum = acc_reg;
    for (int i = 0; i < p_mul_bits_per_cycle; i++) begin
      mul_sum = mul_sum + mul_pp[i];
    end
  end

  logic [p_nbits:0] div_shift;
  logic [p_nbits:0] div_diff;
  assign div_shift = {acc_reg, a_reg[p_nbits-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};

  logic               in_signed;
  logic               is_last;
  logic [p_nbits-1:0] calc_result;
  logic [p_nbits-1:0] quo_signed;
  logic [p_nbits-1:0] rem_signed;

  always_comb begin
    state_next  = state_reg;
    fn_next     = fn_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    acc_next    = acc_reg;
    count_next  = count_reg;
    sign_a_next = sign_a_reg;
    sign_b_next = sign_b_reg;
    b_zero_next = b_zero_reg;
    result_next = result_reg;
    in_signed   = (istream_msg_fn == FN_DIV) || (istream_msg_fn == FN_REM);
    is_last     = 1'b0;
    calc_result = '0;
    quo_signed  = '0;
    rem_signed  = '0;

    case (state_reg)
      IDLE: begin
        if (istream_val) begin
          state_next  = CALC;
          fn_next     = istream_msg_fn;
          count_next  = '0;
          acc_next    = '0;
          sign_a_next = in_signed && istream_msg_a[p_nbits-1];
          sign_b_next = in_signed && istream_msg_b[p_nbits-1];
          a_next      = sign_a_next ? -istream_msg_a : istream_msg_a;
          b_next      = sign_b_next ? -istream_msg_b : istream_msg_b;
          b_zero_next = (istream_msg_b == '0);
        end
      end

      CALC: begin
        count_next = count_reg + 1'b1;
        if (fn_reg == FN_MUL) begin
          acc_next    = mul_sum;
          a_next      = a_reg << p_mul_bits_per_cycle;
          b_next      = b_reg >> p_mul_bits_per_cycle;
          calc_result = mul_sum;
          is_last     = (count_reg == MUL_LAST);
`ifdef INT_MULDIV_ITER_EARLY_TERM_EN
          is_last     = is_last || (b_next == '0);
`endif
        end else if (fn_reg == FN_DIV || fn_reg == FN_DIVU ||
                     fn_reg == FN_REM || fn_reg == FN_REMU) begin
          // Restoring step: keep the trial difference only when it did not go negative.
          acc_next   = div_diff[p_nbits] ? div_shift[p_nbits-1:0] : div_diff[p_nbits-1:0];
          a_next     = {a_reg[p_nbits-2:0], ~div_diff[p_nbits]};
          is_last    = (count_reg == DIV_LAST);
          quo_signed = (sign_a_reg ^ sign_b_reg) ? -a_next : a_next;
          rem_signed = sign_a_reg ? -acc_next : acc_next;
          // With a zero divisor the remainder path naturally yields |a|, so only the quotient needs forcing.
          if (fn_reg == FN_DIV || fn_reg == FN_DIVU) begin
            calc_result = b_zero_reg ? '1 : quo_signed;
          end else begin
            calc_result = rem_signed;
          end
        end else begin
          is_last     = 1'b1;
          calc_result = '0;
        end
        if (is_last) begin
          state_next  = DONE;
          result_next = calc_result;
        end
      end

      DONE: begin
        if (ostream_rdy) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      fn_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      b_zero_reg <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      fn_reg     <= fn_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      acc_reg    <= acc_next;
      count_reg  <= count_next;
      sign_a_reg <= sign_a_next;
      sign_b_reg <= sign_b_next;
      b_zero_reg <= b_zero_next;
      result_reg <= result_next;
    end
  end

  assign istream_rdy = (state_reg == IDLE) && !reset;
  assign ostream_val = (state_reg == DONE);
  assign ostream_msg = result_reg;

endmodule

// File: tb/tb_int_muldiv_iter.sv
// Self-checking bench for int_muldiv_iter: directed corner cases, randomized ops, backpressure and mid-op reset.
`timescale 1ns/1ps
module tb_int_muldiv_iter;

  localparam int NB  = 32;
  localparam int BPC = 1;

  logic          clk;
  logic          reset;
  logic          istream_val;
  logic          istream_rdy;
  logic [2:0]    istream_msg_fn;
  logic [NB-1:0] istream_msg_a;
  logic [NB-1:0] istream_msg_b;
  logic          ostream_val;
  logic          ostream_rdy;
  logic [NB-1:0] ostream_msg;

  int checks = 0;
  int errors = 0;

  int_muldiv_iter #(
    .p_nbits              (NB),
    .p_mul_bits_per_cycle (BPC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .istream_val    (istream_val),
    .istream_rdy    (istream_rdy),
    .istream_msg_fn (istream_msg_fn),
    .istream_msg_a  (istream_msg_a),
    .istream_msg_b  (istream_msg_b),
    .ostream_val    (ostream_val),
    .ostream_rdy    (ostream_rdy),
    .ostream_msg    (ostream_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: plain SV operators on signed/unsigned values plus the corner-case rules.
  function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (fn)
      3'd0: return a * b;
      3'd1: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd2: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd3: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      3'd4: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Edges counted from the accept edge (edge 1) through the edge that raises ostream_val: K CALC cycles + 1.
  function automatic int exp_edges(input logic [2:0] fn, input logic [31:0] b);
    int k;
    if (fn == 3'd0) begin
      k = NB / BPC;
`ifdef INT_MULDIV_ITER_EARLY_TERM_EN
      k = 1;
      for (int i = 0; i < NB; i++) begin
        if (b[i]) k = (i + BPC) / BPC;
      end
`endif
    end else if (fn <= 3'd4) begin
      k = NB;
    end else begin
      k = 1;
    end
    return k + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic start_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                          output int waited);
    istream_val    = 1'b1;
    istream_msg_fn = fn;
    istream_msg_a  = a;
    istream_msg_b  = b;
    waited = 0;
    while (!istream_rdy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!istream_rdy) begin
      check("accept_timeout", 64'd0, 64'd1);
      istream_val = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      istream_val    = 1'b0;
      istream_msg_fn = 3'($urandom);
      istream_msg_a  = 32'($urandom);
      istream_msg_b  = 32'($urandom);
      check("rdy_after_accept", 64'(istream_rdy), 64'd0);
    end
  endtask

  // Waits for the result, checks latency/value, applies backpressure, then completes the handshake.
  task automatic finish_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                           input int stall, input bit chain,
                           input logic [2:0] nfn, input logic [31:0] na, input logic [31:0] nb);
    int lat;
    logic [31:0] exp_msg;
    logic [31:0] held;
    exp_msg = model(fn, a, b);
    lat = 1;
    while (!ostream_val && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!ostream_val) begin
      check("done_timeout", 64'd0, 64'd1);
      return;
    end
    check("latency", 64'(lat), 64'(exp_edges(fn, b)));
    check("result", 64'(ostream_msg), 64'(exp_msg));
    check("rdy_in_done", 64'(istream_rdy), 64'd0);
    $display("op fn=%0d a=%08h b=%08h msg=%08h exp=%08h edges=%0d stall=%0d",
             fn, a, b, ostream_msg, exp_msg, lat, stall);
    held = ostream_msg;
    for (int s = 1; s < stall; s++) begin
      @(negedge clk);
      check("bp_val", 64'(ostream_val), 64'd1);
      check("bp_msg", 64'(ostream_msg), 64'(held));
      check("bp_rdy", 64'(istream_rdy), 64'd0);
    end
    if (chain) begin
      istream_val    = 1'b1;
      istream_msg_fn = nfn;
      istream_msg_a  = na;
      istream_msg_b  = nb;
    end
    ostream_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ostream_rdy = 1'b0;
    check("val_after_hs", 64'(ostream_val), 64'd0);
    check("rdy_after_hs", 64'(istream_rdy), 64'd1);
  endtask

  task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b, input int stall);
    int w;
    start_op(fn, a, b, w);
    finish_op(fn, a, b, stall, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  initial begin
    int w;
    reset          = 1'b1;
    istream_val    = 1'b0;
    istream_msg_fn = 3'd0;
    istream_msg_a  = '0;
    istream_msg_b  = '0;
    ostream_rdy    = 1'b0;

    #12;
    check("reset_irdy", 64'(istream_rdy), 64'd0);
    check("reset_oval", 64'(ostream_val), 64'd0);
    check("reset_omsg", 64'(ostream_msg), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_irdy", 64'(istream_rdy), 64'd1);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(3'd0, 32'd12345, 32'd3, 0);
    run_op(3'd0, 32'hDEAD_BEEF, 32'd0, 0);
    for (int f = 1; f <= 4; f++) run_op(3'(f), 32'hFFFF_FFF9, 32'd2, 0);
    for (int f = 1; f <= 4; f++) run_op(3'(f), 32'd5, 32'd0, 0);
    for (int f = 1; f <= 4; f++) run_op(3'(f), 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd0, 0);
    for (int f = 5; f <= 7; f++) run_op(3'(f), 32'h1234_5678, 32'd9, 0);

    // Backpressure, with the next request already waiting when the output handshake completes.
    start_op(3'd0, 32'd123, 32'd456, w);
    finish_op(3'd0, 32'd123, 32'd456, 5, 1'b1, 3'd2, 32'd100, 32'd7);
    start_op(3'd2, 32'd100, 32'd7, w);
    check("accept_one_cycle", 64'(w), 64'd0);
    finish_op(3'd2, 32'd100, 32'd7, 0, 1'b0, 3'd0, 32'd0, 32'd0);

    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 2));
    end

    // Reset asserted mid-cycle during CALC cycle 10 of a DIV.
    start_op(3'd1, 32'hFFFF_FF00, 32'd3, w);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_oval", 64'(ostream_val), 64'd0);
    check("abort_irdy", 64'(istream_rdy), 64'd0);
    check("abort_omsg", 64'(ostream_msg), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_rdy_back", 64'(istream_rdy), 64'd1);
    check("abort_no_stale", 64'(ostream_val), 64'd0);
    $display("op reset during DIV calc cycle 10");
    run_op(3'd0, 32'd6, 32'd7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/int_muldiv_iter.md
Name: int_muldiv_iter

Overview:
- Parametrised iterative integer multiply/divide unit for the pipelined processor X stage; successor to the fixed 32-bit iterative multiplier.
- Adds divide/remainder (signed and unsigned), configurable datapath width, and configurable multiply bits-per-cycle.
- Single outstanding operation.
- val/rdy streams on both sides: the pipeline control stalls X on istream_rdy and M on ostream_val.

Parameters:
p_nbits, 32, operand/result width; even, >= 4
p_mul_bits_per_cycle, 1, multiplier bits retired per CALC cycle; must divide p_nbits (1, 2, 4)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
istream_val  input  1  request valid
istream_rdy  output  1  unit can accept request
istream_msg_fn  input  3  op: 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU, 5-7 reserved
istream_msg_a  input  p_nbits  operand a (multiplicand / dividend)
istream_msg_b  input  p_nbits  operand b (multiplier / divisor)
ostream_val  output  1  result valid
ostream_rdy  input  1  consumer ready
ostream_msg  output  p_nbits  result

Behaviour:
- Reset (async, active-high):
  - state=IDLE; counter, accumulator and operand registers cleared.
  - While reset is high: istream_rdy=0, ostream_val=0, ostream_msg=0.
  - Reset mid-CALC or mid-DONE aborts the operation; no result is ever emitted for it.
- FSM states: IDLE, CALC, DONE.
  - istream_rdy = (state==IDLE).
  - ostream_val = (state==DONE).
- IDLE -> CALC on istream_val && istream_rdy.
  - Operands and fn latch on that edge.
  - For signed ops (DIV, REM), latch absolute values plus sign flags.
- CALC runs K cycles:
  - MUL: K = p_nbits/p_mul_bits_per_cycle.
  - DIV/DIVU/REM/REMU: K = p_nbits.
  - Reserved fn: K = 1.
  - CALC -> DONE after the K-th cycle, so ostream_val rises on the (K+1)-th edge after the accept edge.
- MUL:
  - Shift-add; each cycle adds a * (low p_mul_bits_per_cycle bits of b) to the accumulator, then shifts a left and b right by p_mul_bits_per_cycle.
  - Result is the low p_nbits of the product (identical for signed/unsigned); overflow bits are discarded.
- Divide: restoring, one quotient bit per cycle on the unsigned magnitudes.
  - Signed quotient is negated iff sign_a ^ sign_b.
  - Signed remainder takes the sign of a.
- Divisor zero (fixed latency K still applies):
  - DIV/DIVU -> all ones.
  - REM/REMU -> a, original signed value.
- Signed overflow (a = most-negative, b = all ones):
  - DIV -> most-negative.
  - REM -> 0.
- Reserved fn: result 0.
- DONE:
  - ostream_msg is held stable until ostream_rdy.
  - ostream_val && ostream_rdy -> IDLE.
  - istream_rdy stays 0 throughout DONE, so a new request is accepted at the earliest one cycle after the output handshake.
- istream_msg changes while not accepted are ignored.
- ostream_msg is registered; no combinational path from any input to ostream_msg or ostream_val.

Optional Feature:
- Macro: INT_MULDIV_ITER_EARLY_TERM_EN.
- Defined:
  - For MUL, CALC -> DONE at the end of any CALC cycle in which the remaining (already shifted) multiplier bits are all zero.
  - MUL latency becomes max(1, ceil(msb_index(b)+1 / p_mul_bits_per_cycle)) CALC cycles.
  - b=0 takes 1 cycle.
  - Divide latency is unchanged.
- Undefined: MUL always takes exactly p_nbits/p_mul_bits_per_cycle CALC cycles.
- Result values are identical in both builds.

Test Plan:
- p_nbits=32, bpc=1, MUL a=7 b=0xFFFFFFFD -> ostream_msg=0xFFFFFFEB, ostream_val 33 edges after accept; with bpc=4 -> 9 edges; with EARLY_TERM_EN and b=3 -> 3 edges.
- Signed divide, a=0xFFFFFFF9 (-7), b=2:
  - DIV -> 0xFFFFFFFD.
  - REM -> 0xFFFFFFFF.
  - DIVU -> 0x7FFFFFFC.
  - REMU -> 1.
- Divide by zero, a=5, b=0:
  - DIV and DIVU -> 0xFFFFFFFF.
  - REM and REMU -> 5.
  - Latency still 33 edges.
- Overflow, a=0x80000000, b=0xFFFFFFFF:
  - DIV -> 0x80000000.
  - REM -> 0.
  - DIVU -> 0.
  - REMU -> 0x80000000.
- Backpressure: ostream_rdy low 5 cycles after ostream_val rises -> ostream_msg and ostream_val held stable, istream_rdy=0 throughout; a new request with istream_val held high is accepted exactly one cycle after the output handshake.
- Reset asserted asynchronously in CALC cycle 10 of a DIV:
  - ostream_val=0 and istream_rdy=0 immediately.
  - After deassertion, istream_rdy=1.
  - A following MUL 6*7 returns 42 with no stale result emitted.
